// File: rtl/lsab_pkg.sv
// Shared constants and types for the lsab FIFO reader.
// Holds channel selects, data/ancillary widths, read latency and FSM states.
// No logic; imported by the reader and its skid buffer.
package lsab_pkg;

  localparam logic [1:0] LSAB_FIFO_0 = 2'h0;
  localparam logic [1:0] LSAB_FIFO_1 = 2'h1;
  localparam logic [1:0] LSAB_FIFO_2 = 2'h2;
  localparam logic [1:0] LSAB_FIFO_3 = 2'h3;

  localparam int LSAB_DATA_W       = 32;
  localparam int LSAB_ANCILL_W     = 3;
  localparam int LSAB_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FLUSH     = 2'd2,
    BLOCK_END = 2'd3
  } lsab_state_e;

  // One skid entry: the word plus the block-framing marker carried with it.
  typedef struct packed {
    logic [LSAB_DATA_W-1:0]   data;
    logic                     last;
    logic [LSAB_ANCILL_W-1:0] tag;
  } lsab_word_t;

  // Saturating 16-bit increment for word counters.
  function automatic logic [15:0] lsab_sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lsab_reader_skid.sv
// Skid buffer for the lsab reader: DEPTH-entry synchronous FIFO of lsab_word_t.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the reader's credit scheme keeps pushes below capacity.
module lsab_reader_skid
  import lsab_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  lsab_word_t push_word,
  input  logic       pop,
  output lsab_word_t head,
  output logic       empty,
  output logic [AW:0] count
);

  lsab_word_t  mem_q [DEPTH];
  lsab_word_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  // A push into a full buffer is dropped rather than corrupting the head.
  assign push_ok = push && (count_q != (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy; pointers wrap as DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lsab_reader.sv
// Consumer end of one lsab FIFO channel: issues READ, realigns INT/ANCILL into LAST/TAG.
// Latency: READ in cycle n gives VALID at n+3 (2-cycle FIFO read plus skid write).
// Backpressure: credits cover skid + in-flight reads, so ACK low halts READ without loss.
// Optional: LSAB_READER_COUNT_EN adds WORD_COUNT (words accepted in the current block).
module lsab_reader
  import lsab_pkg::*;
#(
  parameter logic [1:0] FIFO_SEL = LSAB_FIFO_0,
  parameter int         DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     BLOCK_MODE,
  output logic                     READ,
  output logic [1:0]               READ_FIFO,
  output logic                     CAREOF_INT,
  input  logic [LSAB_DATA_W-1:0]   FIFO_DATA,
  input  logic                     FIFO_EMPTY,
  input  logic                     FIFO_STOP,
  input  logic                     FIFO_INT,
  input  logic [LSAB_ANCILL_W-1:0] FIFO_ANCILL,
  output logic [LSAB_DATA_W-1:0]   DATA,
  output logic                     VALID,
  output logic                     LAST,
  output logic [LSAB_ANCILL_W-1:0] TAG,
  input  logic                     ACK,
  output logic                     BUSY,
  output logic                     DONE
`ifdef LSAB_READER_COUNT_EN
  ,
  output logic [15:0]              WORD_COUNT
`endif
);

  localparam int AW = $clog2(DEPTH);

  lsab_state_e state_q, state_d;
  logic        rd1_q, rd1_d;
  logic        rd2_q, rd2_d;
  logic        int2_q, int2_d;
  logic [LSAB_ANCILL_W-1:0] anc2_q, anc2_d;

  logic          skid_empty;
  logic [AW:0]   skid_count;
  lsab_word_t    skid_head;
  lsab_word_t    push_word;
  logic [AW+1:0] inflight;
  logic          credit_ok;
  logic          marker_hit;
  logic          pop;
  logic          done_c;
  logic          fifo_empty_unused;

  // STOP already accounts for an empty FIFO; EMPTY is informational only.
  assign fifo_empty_unused = FIFO_EMPTY;

  assign READ_FIFO  = FIFO_SEL;
  assign CAREOF_INT = BLOCK_MODE;

  // Words owned by the reader: buffered plus both read-pipeline stages.
  always_comb begin
    inflight = {1'b0, skid_count} + (AW+2)'(rd1_q) + (AW+2)'(rd2_q);
  end

  assign credit_ok  = inflight < (AW+2)'(DEPTH);
  assign READ       = (state_q == RUN) && !FIFO_STOP && credit_ok;
  assign marker_hit = rd1_q && FIFO_INT;
  assign VALID      = !skid_empty;
  assign pop        = VALID && ACK;
  assign DATA       = VALID ? skid_head.data : '0;
  assign LAST       = VALID && skid_head.last;
  assign TAG        = VALID ? skid_head.tag : '0;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = done_c;

  // INT/ANCILL arrive one cycle ahead of the data; carry them down with rd2.
  always_comb begin
    rd1_d  = READ;
    rd2_d  = rd1_q;
    int2_d = marker_hit;
    anc2_d = marker_hit ? FIFO_ANCILL : '0;
  end

  assign push_word = '{data: FIFO_DATA, last: int2_q, tag: anc2_q};

  lsab_reader_skid #(
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (rd2_q),
    .push_word (push_word),
    .pop       (pop),
    .head      (skid_head),
    .empty     (skid_empty),
    .count     (skid_count)
  );

  // Control FSM; a block marker takes priority over ENABLE dropping so the block completes.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE) state_d = RUN;
      end
      RUN: begin
        if (BLOCK_MODE && marker_hit) state_d = BLOCK_END;
        else if (!ENABLE)             state_d = FLUSH;
      end
      FLUSH: begin
        if (!rd1_q && !rd2_q && skid_empty) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      BLOCK_END: begin
        if (pop && skid_head.last) begin
          done_c  = 1'b1;
          state_d = ENABLE ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and read-pipeline registers; reset discards anything in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rd1_q   <= 1'b0;
      rd2_q   <= 1'b0;
      int2_q  <= 1'b0;
      anc2_q  <= '0;
    end else begin
      state_q <= state_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      int2_q  <= int2_d;
      anc2_q  <= anc2_d;
    end
  end

`ifdef LSAB_READER_COUNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  // Words accepted in the current block; the LAST word closes the block.
  always_comb begin
    wcnt_d = wcnt_q;
    if (pop) wcnt_d = skid_head.last ? 16'h0 : lsab_sat_inc(wcnt_q);
  end

  // Block word counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end

  assign WORD_COUNT = VALID ? lsab_sat_inc(wcnt_q) : 16'h0;
`endif

  // A marker outside the rd1 slot cannot be attached to any word.
  a_int_aligned: assert property (@(posedge CLK) disable iff (!RST) FIFO_INT |-> rd1_q);

endmodule

// File: tb/tb_lsab_reader.sv
`timescale 1ns/1ps
module tb_lsab_reader;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE, BLOCK_MODE, READ, CAREOF_INT;
  logic [1:0]  READ_FIFO;
  logic [31:0] FIFO_DATA, DATA;
  logic        FIFO_EMPTY, FIFO_STOP, FIFO_INT;
  logic [2:0]  FIFO_ANCILL, TAG;
  logic        VALID, LAST, ACK, BUSY, DONE;
`ifdef LSAB_READER_COUNT_EN
  logic [15:0] WORD_COUNT;
`endif

  always #5 CLK = ~CLK;

  lsab_reader #(.FIFO_SEL(2'h2), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .BLOCK_MODE(BLOCK_MODE),
    .READ(READ), .READ_FIFO(READ_FIFO), .CAREOF_INT(CAREOF_INT),
    .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_STOP(FIFO_STOP),
    .FIFO_INT(FIFO_INT), .FIFO_ANCILL(FIFO_ANCILL),
    .DATA(DATA), .VALID(VALID), .LAST(LAST), .TAG(TAG), .ACK(ACK),
    .BUSY(BUSY), .DONE(DONE)
`ifdef LSAB_READER_COUNT_EN
    , .WORD_COUNT(WORD_COUNT)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        mark;
    logic [2:0]  anc;
  } word_t;

  // Reference model: the FIFO contents, its 2-stage read pipe, and the words owed to the sink.
  word_t src_q[$];
  word_t exp_q[$];
  logic  s1_vld, s2_vld;
  word_t s1_w, s2_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_pct, stop_pct;
  logic ack_en, stop_en, track_hold, hold;
  int n_read, n_acc, n_done, n_last, n_valid, hold_reads;
  int first_read_cyc, first_valid_cyc, acc_at_done;
  logic done_last;
  logic [2:0] done_tag;
  int wc_at_last, wc_after;
  logic seen_last;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_read = 0; n_acc = 0; n_done = 0; n_last = 0; n_valid = 0; hold_reads = 0;
    first_read_cyc = -1; first_valid_cyc = -1; acc_at_done = -1;
    done_last = 0; done_tag = 0; hold = 0; track_hold = 0;
    wc_at_last = -1; wc_after = -1; seen_last = 0;
  endtask

  task automatic do_reset();
    RST = 1'b0; ENABLE = 0; BLOCK_MODE = 0; ACK = 0;
    FIFO_DATA = 0; FIFO_EMPTY = 1; FIFO_STOP = 1; FIFO_INT = 0; FIFO_ANCILL = 0;
    src_q.delete(); exp_q.delete(); s1_vld = 0; s2_vld = 0;
    ack_en = 1; ack_pct = 100; stop_en = 0; stop_pct = 0;
    clr_stats();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // One clock: drive FIFO/sink inputs, observe and score, advance the model. Entered at negedge.
  task automatic step();
    word_t w;
    logic acc;
    ACK         = ack_en && (int'($urandom_range(99)) < ack_pct);
    FIFO_EMPTY  = (src_q.size() == 0);
    FIFO_STOP   = (src_q.size() == 0) || (stop_en && int'($urandom_range(99)) < stop_pct);
    FIFO_INT    = s1_vld && s1_w.mark;
    FIFO_ANCILL = s1_vld ? s1_w.anc : 3'h0;
    FIFO_DATA   = s2_vld ? s2_w.data : 32'hdead_beef;
    #1;
    acc = VALID && ACK;
    if (VALID) n_valid++;
    if (VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (acc) begin
      if (exp_q.size() == 0) chk("acc_unexpected", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("acc_data", DATA, w.data);
        chk("acc_last", LAST, w.mark);
        chk("acc_tag", TAG, w.mark ? w.anc : 3'h0);
      end
`ifdef LSAB_READER_COUNT_EN
      if (seen_last && wc_after < 0) wc_after = WORD_COUNT;
      if (LAST && !seen_last) begin wc_at_last = WORD_COUNT; seen_last = 1; end
`endif
      n_acc++;
      if (LAST) n_last++;
    end
    if (DONE) begin
      n_done++;
      acc_at_done = n_acc;
      done_last   = acc && LAST;
      done_tag    = TAG;
    end
    if (track_hold) begin
      if (hold && READ) hold_reads++;
      if (DONE) hold = 0;
      if (BLOCK_MODE && FIFO_INT) hold = 1;
    end
    s2_vld = s1_vld; s2_w = s1_w; s1_vld = 0;
    if (READ) begin
      chk("read_stop", FIFO_STOP, 0);
      if (first_read_cyc < 0) first_read_cyc = cyc;
      n_read++;
      if (src_q.size() > 0) begin
        s1_w = src_q.pop_front(); s1_vld = 1;
        exp_q.push_back(s1_w);
      end
      chk("credit", exp_q.size() <= DEPTH, 1);
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic load(input int n, input logic [31:0] base, input int mark_idx, input logic [2:0] anc);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = base + i;
      w.mark = (i == mark_idx);
      w.anc  = (i == mark_idx) ? anc : 3'($urandom_range(7));
      src_q.push_back(w);
    end
  endtask

  task automatic run_until_empty(input int maxc);
    int n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < maxc) begin step(); n++; end
    chk("drain_timeout", exp_q.size() + src_q.size(), 0);
  endtask

  task automatic finish_idle();
    int n = 0;
    ENABLE = 0;
    while (BUSY && n < 60) begin step(); n++; end
    chk("idle_timeout", BUSY, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t w;
    // Reset state, including asynchronous assertion away from any edge.
    RST = 1'b1; ENABLE = 0; BLOCK_MODE = 1; ACK = 0;
    FIFO_DATA = 0; FIFO_EMPTY = 1; FIFO_STOP = 1; FIFO_INT = 0; FIFO_ANCILL = 0;
    #3 RST = 1'b0;
    #1;
    chk("rst_valid", VALID, 0); chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0);
    chk("rst_last", LAST, 0);   chk("rst_data", DATA, 0); chk("rst_tag", TAG, 0);
    chk("rst_read", READ, 0);   chk("read_fifo", READ_FIFO, 2'h2);
    chk("careof_1", CAREOF_INT, 1);
    BLOCK_MODE = 0; #1;
    chk("careof_0", CAREOF_INT, 0);
    do_reset();

    // Streaming: 8 plain words, sink always ready.
    load(8, 32'h100, -1, 3'h0);
    ENABLE = 1;
    step();
    run_until_empty(80);
    chk("stream_busy", BUSY, 1);
    chk("stream_count", n_acc, 8);
    chk("stream_no_last", n_last, 0);
    chk("stream_latency", first_valid_cyc - first_read_cyc, 3);
    finish_idle();
    chk("stream_flush_done", n_done, 1);

    // Backpressure: sink stalled, only DEPTH reads may be outstanding.
    do_reset();
    load(8, 32'h200, -1, 3'h0);
    ack_en = 0; ENABLE = 1;
    repeat (20) step();
    chk("bp_reads", n_read, 4);
    chk("bp_valid", VALID, 1);
    ack_en = 1;
    run_until_empty(80);
    chk("bp_count", n_acc, 8);
    finish_idle();

    // Block mode: word 3 of 6 carries the marker with ANCILL=5.
    do_reset();
    load(6, 32'h300, 3, 3'h5);
    BLOCK_MODE = 1; ENABLE = 1; track_hold = 1;
    for (int i = 0; i < 60 && n_done == 0; i++) step();
    chk("blk_done_seen", n_done, 1);
    chk("blk_acc_at_done", acc_at_done, 4);
    chk("blk_done_on_last", done_last, 1);
    chk("blk_tag", done_tag, 3'h5);
    chk("blk_no_read_hold", hold_reads, 0);
    run_until_empty(80);
    chk("blk_total", n_acc, 6);
    chk("blk_last_count", n_last, 1);
    BLOCK_MODE = 0;
    finish_idle();

    // STOP gating: drain to empty, idle on STOP, then refill.
    do_reset();
    load(3, 32'h400, -1, 3'h0);
    ENABLE = 1;
    repeat (30) step();
    chk("stop_drained", n_acc, 3);
    chk("stop_reads", n_read, 3);
    load(5, 32'h410, 2, 3'h6);
    run_until_empty(80);
    chk("stop_refill", n_acc, 8);
    stop_en = 1; stop_pct = 50; ack_pct = 70;
    load(12, 32'h480, 7, 3'h1);
    run_until_empty(400);
    chk("stop_rand", n_acc, 20);
    finish_idle();

    // Flush: ENABLE drops with 2 reads in flight.
    do_reset();
    load(6, 32'h500, -1, 3'h0);
    ENABLE = 1;
    for (int i = 0; i < 20 && n_read == 0; i++) step();
    ENABLE = 0;
    for (int i = 0; i < 30 && (BUSY || i == 0); i++) step();
    chk("flush_reads", n_read, 2);
    chk("flush_acc", n_acc, 2);
    chk("flush_done", n_done, 1);
    chk("flush_idle", BUSY, 0);
    chk("flush_left", src_q.size(), 4);

    // Reset mid-operation with 2 reads in flight.
    do_reset();
    load(6, 32'h600, -1, 3'h0);
    ENABLE = 1;
    for (int i = 0; i < 20 && n_read < 2; i++) step();
    RST = 1'b0;
    #1;
    chk("mrst_valid", VALID, 0); chk("mrst_busy", BUSY, 0);
    chk("mrst_read", READ, 0);   chk("mrst_data", DATA, 0);
    s1_vld = 0; s2_vld = 0; exp_q.delete(); ENABLE = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    n_valid = 0;
    repeat (10) step();
    chk("mrst_no_valid", n_valid, 0);

    // Randomised streams, with and without block mode.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        w.data = $urandom;
        w.mark = ($urandom_range(4) == 0);
        w.anc  = 3'($urandom_range(7));
        src_q.push_back(w);
      end
      BLOCK_MODE = (it == 2);
      ack_pct = 30 + int'($urandom_range(70));
      stop_en = 1; stop_pct = 30; ENABLE = 1;
      run_until_empty(800);
      chk("rand_count", n_acc, 20);
      finish_idle();
    end

`ifdef LSAB_READER_COUNT_EN
    // Word count: 5-word block, then first word of the next block.
    do_reset();
    load(8, 32'h700, 4, 3'h2);
    BLOCK_MODE = 1; ENABLE = 1;
    run_until_empty(80);
    chk("wc_last", wc_at_last, 5);
    chk("wc_next", wc_after, 1);
    BLOCK_MODE = 0;
    finish_idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
